dram_bank_timer: RTL

//  Per-bank DDR4 state and timing tracker, parametrised over bank groups and banks.

---
 rtl/dram_bank_timer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dram_bank_timer.sv
// Per-bank DDR4 state and timing tracker: records issued ACT/RD/WR/PRE per bank and
// answers a combinational legality query against tRCD/tRP/tRAS/tCCD/tRRD/tFAW.
module dram_bank_timer #(
    parameter int N_BG    = 4,
    parameter int N_BA    = 4,
    parameter int ROW_W   = 15,
    parameter int CNT_W   = 8,
    parameter int T_RCD   = 12,
    parameter int T_RP    = 10,
    parameter int T_RAS   = 19,
    parameter int T_CCD_S = 4,
    parameter int T_CCD_L = 5,
    parameter int T_RRD_S = 4,
    parameter int T_RRD_L = 4,
    parameter int T_FAW   = 25
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      cmd_valid,
    input  logic [1:0]                cmd_type,
    input  logic [$clog2(N_BG)-1:0]   cmd_bg,
    input  logic [$clog2(N_BA)-1:0]   cmd_ba,
    input  logic [ROW_W-1:0]          cmd_row,
    input  logic [1:0]                q_type,
    input  logic [$clog2(N_BG)-1:0]   q_bg,
    input  logic [$clog2(N_BA)-1:0]   q_ba,
    input  logic [ROW_W-1:0]          q_row,
    output logic                      q_ok,
    output logic                      q_hit,
    output logic [N_BG*N_BA-1:0]      bank_open,
    output logic                      err_illegal
);

    localparam int BG_W = $clog2(N_BG);
    localparam int BA_W = $clog2(N_BA);
    localparam int NB_W = BG_W + BA_W;
    localparam int NB   = N_BG * N_BA;

    localparam logic [1:0] CMD_ACT = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_WR  = 2'd2;
    localparam logic [1:0] CMD_PRE = 2'd3;

    localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RAS   = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] LD_CCD_S = CNT_W'(T_CCD_S - 1);
    localparam logic [CNT_W-1:0] LD_CCD_L = CNT_W'(T_CCD_L - 1);
    localparam logic [CNT_W-1:0] LD_RRD_S = CNT_W'(T_RRD_S - 1);
    localparam logic [CNT_W-1:0] LD_RRD_L = CNT_W'(T_RRD_L - 1);
    localparam logic [CNT_W-1:0] LD_FAW   = CNT_W'(T_FAW - 1);

    typedef enum logic [1:0] {
        BANK_IDLE   = 2'd0,
        BANK_ACTIVE = 2'd1
    } bank_state_t;

    bank_state_t       bank_state_r [NB];
    logic [ROW_W-1:0]  row_r        [NB];
    logic [CNT_W-1:0]  rcd_r        [NB];
    logic [CNT_W-1:0]  ras_r        [NB];
    logic [CNT_W-1:0]  rp_r         [NB];
    logic [CNT_W-1:0]  ccd_l_r      [N_BG];
    logic [CNT_W-1:0]  rrd_l_r      [N_BG];
    logic [CNT_W-1:0]  ccd_s_r;
    logic [CNT_W-1:0]  rrd_s_r;
    logic [CNT_W-1:0]  faw_r        [4];
    logic [1:0]        faw_ptr_r;
    logic              err_r;

    logic              faw_free_s;
    logic              cmd_legal_s;
    logic              fire_s;
    logic [NB_W-1:0]   cmd_idx_s;
    logic [NB_W-1:0]   q_idx_s;

    // Saturating down-count shared by every timer.
    function automatic logic [CNT_W-1:0] dec_f(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == '0) begin
            r = '0;
        end else begin
            r = v - CNT_W'(1);
        end
        return r;
    endfunction

    // Legality of a command against the current (pre-update) state.
    function automatic logic legal_f(input logic [1:0] typ, input logic [BG_W-1:0] bg,
                                     input logic [BA_W-1:0] ba);
        logic [NB_W-1:0] idx;
        logic            ok;
        idx = {bg, ba};
        ok  = 1'b0;
        case (typ)
            CMD_ACT: ok = (bank_state_r[idx] == BANK_IDLE) && (rp_r[idx] == '0) &&
                          (rrd_l_r[bg] == '0) && (rrd_s_r == '0) && faw_free_s;
            CMD_RD,
            CMD_WR:  ok = (bank_state_r[idx] == BANK_ACTIVE) && (rcd_r[idx] == '0) &&
                          (ccd_l_r[bg] == '0) && (ccd_s_r == '0);
            CMD_PRE: ok = (bank_state_r[idx] == BANK_ACTIVE) && (ras_r[idx] == '0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The oldest ring entry always holds the smallest count, so any zero frees a slot.
    always_comb begin
        faw_free_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (faw_r[i] == '0) begin
                faw_free_s = 1'b1;
            end else begin
                faw_free_s = faw_free_s;
            end
        end
    end

    // Query answer and issued-command qualification.
    always_comb begin
        cmd_idx_s   = {cmd_bg, cmd_ba};
        q_idx_s     = {q_bg, q_ba};
        cmd_legal_s = legal_f(cmd_type, cmd_bg, cmd_ba);
        fire_s      = cmd_valid & cmd_legal_s;
        q_ok        = legal_f(q_type, q_bg, q_ba);
        q_hit       = (bank_state_r[q_idx_s] == BANK_ACTIVE) && (row_r[q_idx_s] == q_row);
    end

    // Bank-open vector straight from the bank state registers.
    always_comb begin
        bank_open = '0;
        for (int i = 0; i < NB; i++) begin
            bank_open[i] = (bank_state_r[i] == BANK_ACTIVE);
        end
    end

    assign err_illegal = err_r;

    // Per-bank state, open row and rcd/ras/rp timers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NB; i++) begin
                bank_state_r[i] <= BANK_IDLE;
                row_r[i]        <= '0;
                rcd_r[i]        <= '0;
                ras_r[i]        <= '0;
                rp_r[i]         <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                rcd_r[i] <= dec_f(rcd_r[i]);
                ras_r[i] <= dec_f(ras_r[i]);
                rp_r[i]  <= dec_f(rp_r[i]);
                if (fire_s && (cmd_idx_s == NB_W'(i))) begin
                    case (cmd_type)
                        CMD_ACT: begin
                            bank_state_r[i] <= BANK_ACTIVE;
                            row_r[i]        <= cmd_row;
                            rcd_r[i]        <= LD_RCD;
                            ras_r[i]        <= LD_RAS;
                        end
                        CMD_PRE: begin
                            bank_state_r[i] <= BANK_IDLE;
                            rp_r[i]         <= LD_RP;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Per-bank-group ccd_l/rrd_l timers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int g = 0; g < N_BG; g++) begin
                ccd_l_r[g] <= '0;
                rrd_l_r[g] <= '0;
            end
        end else begin
            for (int g = 0; g < N_BG; g++) begin
                ccd_l_r[g] <= dec_f(ccd_l_r[g]);
                rrd_l_r[g] <= dec_f(rrd_l_r[g]);
                if (fire_s && (cmd_bg == BG_W'(g))) begin
                    case (cmd_type)
                        CMD_ACT:        rrd_l_r[g] <= LD_RRD_L;
                        CMD_RD, CMD_WR: ccd_l_r[g] <= LD_CCD_L;
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Global ccd_s/rrd_s timers, four-activate window ring and the error pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ccd_s_r   <= '0;
            rrd_s_r   <= '0;
            faw_ptr_r <= 2'd0;
            err_r     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                faw_r[i] <= '0;
            end
        end else begin
            ccd_s_r <= dec_f(ccd_s_r);
            rrd_s_r <= dec_f(rrd_s_r);
            err_r   <= cmd_valid & ~cmd_legal_s;
            for (int i = 0; i < 4; i++) begin
                faw_r[i] <= dec_f(faw_r[i]);
            end
            if (fire_s) begin
                case (cmd_type)
                    CMD_ACT: begin
                        rrd_s_r          <= LD_RRD_S;
                        faw_r[faw_ptr_r] <= LD_FAW;
                        faw_ptr_r        <= faw_ptr_r + 2'd1;
                    end
                    CMD_RD, CMD_WR: ccd_s_r <= LD_CCD_S;
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
